// File: rtl/rs_relay_pipeline_fifo.sv
// Relay-station pipeline: LEVEL forward data/write stages, LEVEL backward credit stages, and a
// tail FIFO that absorbs in-flight words. Optional occupancy statistics under RS_PP_OCCUPANCY_EN.
module rs_relay_pipeline_fifo #(
  parameter  int DATA_WIDTH = 32,
  parameter  int LEVEL      = 6,
  parameter  int TAIL_DEPTH = 16,
  localparam int CNT_WIDTH  = $clog2(TAIL_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] if_din,
  input  logic                  if_write,
  output logic                  if_full_n,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  input  logic                  if_read
`ifdef RS_PP_OCCUPANCY_EN
  ,
  output logic [CNT_WIDTH-1:0]  stat_occ,
  output logic [CNT_WIDTH-1:0]  stat_max_occ
`endif
);
  localparam int                   PTR_WIDTH = (TAIL_DEPTH > 1) ? $clog2(TAIL_DEPTH) : 1;
  localparam logic [PTR_WIDTH-1:0] LAST_PTR  = PTR_WIDTH'(TAIL_DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT  = CNT_WIDTH'(TAIL_DEPTH);

  if (TAIL_DEPTH < 2 * LEVEL + 1) begin : g_bad_depth
    $error("rs_relay_pipeline_fifo: TAIL_DEPTH must be >= 2*LEVEL+1");
  end

  logic [DATA_WIDTH-1:0] r_mem [TAIL_DEPTH];
  logic [PTR_WIDTH-1:0]  r_rd_ptr;
  logic [PTR_WIDTH-1:0]  r_wr_ptr;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [CNT_WIDTH-1:0]  w_count_nxt;
  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_push_data;

  assign w_accept   = if_write & if_full_n;
  assign w_pop      = if_read & if_empty_n;
  assign if_empty_n = (r_count != '0);
  assign if_dout    = r_mem[r_rd_ptr];

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_WIDTH'(1);
  endfunction

  generate
    if (LEVEL == 0) begin : g_direct
      assign w_push      = w_accept;
      assign w_push_data = if_din;
      assign if_full_n   = !reset && (r_count < FULL_CNT);
    end else begin : g_relay
      logic                  w_full_n_int;
      logic [LEVEL-1:0]      r_fwd_valid;
      logic [LEVEL-1:0]      r_bwd_full_n;
      logic [DATA_WIDTH-1:0] r_fwd_data [LEVEL];

      // Credit is withheld early enough that every word already in flight still fits.
      assign w_full_n_int = (int'(r_count) + 2 * LEVEL) < TAIL_DEPTH;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_fwd_valid  <= '0;
          r_bwd_full_n <= '0;
        end else begin
          r_fwd_valid[0]  <= w_accept;
          r_bwd_full_n[0] <= w_full_n_int;
          for (int k = 1; k < LEVEL; k++) begin
            r_fwd_valid[k]  <= r_fwd_valid[k-1];
            r_bwd_full_n[k] <= r_bwd_full_n[k-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        r_fwd_data[0] <= if_din;
        for (int k = 1; k < LEVEL; k++) r_fwd_data[k] <= r_fwd_data[k-1];
      end

      assign w_push      = r_fwd_valid[LEVEL-1];
      assign w_push_data = r_fwd_data[LEVEL-1];
      assign if_full_n   = r_bwd_full_n[LEVEL-1];
    end
  endgenerate

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + CNT_WIDTH'(1);
    else if (!w_push && w_pop) w_count_nxt = r_count - CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(w_push && !w_pop && r_count == FULL_CNT))
        else $error("rs_relay_pipeline_fifo: push into full tail FIFO");
    end
  end

`ifdef RS_PP_OCCUPANCY_EN
  logic [CNT_WIDTH-1:0] r_max_occ;

  always_ff @(posedge clk) begin
    if (reset)                         r_max_occ <= '0;
    else if (w_count_nxt > r_max_occ)  r_max_occ <= w_count_nxt;
  end

  assign stat_occ     = r_count;
  assign stat_max_occ = r_max_occ;
`endif

endmodule
